ldmx_daq_link_tx: RTL and testbench
===================================

Name: ldmx_daq_link_tx

Overview:
Front-end link emulator that transmits trigger-driven event frames over the same 32-bit + per-byte K-flag link interface the DAQ write path receives.
Used for DAQ bring-up and regression without HGCROCs: queues L1A requests, then serialises SOE/header/payload/checksum/EOE frames separated by idle words.
Sits in the link clock domain and drives the DAQ link inputs directly, or through a link mux.

Parameters:
PEND_DEPTH, 8, depth of the pending-trigger queue (power of 2, 2..16)
IDLE_GAP, 4, minimum idle words between EOE and the next SOE (>=1)
VALID_PERIOD, 1, link_valid strobe period in clk_link cycles (1..15)

Ports:
clk_link  in  1  link clock, the only clock
reset  in  1  synchronous, active-high
enable  in  1  accept new L1As; low = finish current frame, then idle
l1a  in  1  single-cycle trigger request
bxid  in  12  bunch id captured with l1a
nwords  in  11  payload words per event, sampled at SOE
pattern_sel  in  2  payload pattern: 0 counter, 1 {evt[15:0],idx[15:0]}, 2 LFSR, 3 32'hA5A5A5A5
link_data  out  32  link word
link_is_k  out  4  per-byte K flag
link_valid  out  1  word strobe
pending  out  5  queued triggers
dropped_count  out  16  L1As lost to a full queue, saturating
evt_count  out  32  frames started since reset
active  out  1  high from SOE through EOE inclusive

Behaviour:
- Word encodings (is_k per word):
  - IDLE = 32'h000000BC, 4'b0001
  - SOE = {bxid[11:0], evt_count[11:0], 8'hFB}, 4'b0001
  - HDR = {5'h0, nwords[10:0], evt_count[15:0]}, 4'b0000
  - PAYLOAD, 4'b0000
  - CKSUM = XOR of all payload words (0 if none), 4'b0000
  - EOE = {13'h0, nwords[10:0], 8'hFD}, 4'b0001
- All outputs are registered.
- Reset values: link_data=IDLE, link_is_k=4'b0001, link_valid=0, pending=0, dropped_count=0, evt_count=0, active=0, LFSR=32'h1, idle-gap counter preloaded to IDLE_GAP.
- Reset mid-frame aborts the frame immediately, clears the queue, and emits IDLE the cycle after reset deasserts.
- Strobe: a divider counts 0..VALID_PERIOD-1; link_valid=1 when the divider is 0.
  - The FSM advances only on strobe cycles.
  - link_data holds its value between strobes.
- Queue: FIFO of bxid.
  - Push on l1a && enable when not full.
  - If full and no pop this cycle, the L1A is dropped and dropped_count increments, saturating at 16'hFFFF.
  - Push and pop in the same cycle is legal when full.
  - l1a with enable=0 is ignored and not counted as a drop.
  - pending = occupancy.
- FSM states, each transition on a strobe:
  - IDLE -> SOE when the queue is non-empty, the gap counter is 0, and enable=1. On entry to SOE: pop, latch bxid and nwords, increment evt_count (wraps), clear checksum and word index.
  - SOE -> HDR.
  - HDR -> PAY if the latched nwords != 0, else -> CKS.
  - PAY: emit one word per strobe, XOR it into the checksum, increment the index; -> CKS after word nwords-1.
  - CKS -> EOE.
  - EOE -> IDLE, reloading the gap counter to IDLE_GAP; the counter decrements on each IDLE strobe.
- enable falling mid-frame does not truncate the frame.
- Patterns:
  - Counter restarts at 0 per event; index is 16 bits.
  - The LFSR steps only when emitting a payload word. Polynomial x^32+x^22+x^2+x+1, Galois form, shift right, mask 32'h80200003.
- Latency (VALID_PERIOD=1, gap expired, queue empty): l1a at cycle t -> SOE on link_data/link_valid at t+2.
- Frame length is nwords+4 strobes; nwords=2047 is the maximum.
- active rises with SOE and falls after EOE.

Test Plan:
- Single L1A, bxid=12'h123, nwords=3, pattern 0 -> SOE 32'h123001FB k=0001; HDR 32'h00030001; payload 0,1,2; CKSUM 32'h00000003; EOE 32'h000003FD k=0001; 4 IDLEs minimum; evt_count=1.
- nwords=0 -> SOE, HDR, CKSUM=0, EOE only; 4 link words; active high for exactly 4 strobes.
- 10 L1As on consecutive cycles with PEND_DEPTH=8 and nwords=16 -> pending peaks at 8, dropped_count=1 (the first L1A is popped at its SOE), 9 frames emitted back-to-back, each separated by exactly IDLE_GAP idles.
- VALID_PERIOD=3, nwords=2 -> link_valid high every 3rd cycle, link_data constant between strobes, frame spans 18 cycles.
- Reset asserted during the PAY of a 100-word event -> the next cycle after release is IDLE k=0001, pending=0, evt_count=0, and no EOE is emitted.
- enable dropped during PAY with 3 queued triggers -> the current frame completes with a correct EOE, no further SOE while enable=0, and the queued triggers are sent after re-enable.

Source files
------------

// File: rtl/ldmx_daq_link_tx_if.sv
// Link-side bus of the DAQ front-end emulator: one 32-bit word with per-byte
// K flags and a word strobe. The transmitter drives it; the DAQ (or a mux) receives it.
interface ldmx_daq_link_tx_if;
  logic [31:0] link_data;
  logic [3:0]  link_is_k;
  logic        link_valid;

  modport master (output link_data, link_is_k, link_valid);
  modport slave  (input  link_data, link_is_k, link_valid);
endinterface

// File: rtl/ldmx_daq_link_tx.sv
// Front-end link emulator: queues L1A triggers and serialises
// SOE/HDR/payload/CKSUM/EOE frames separated by idle words.
module ldmx_daq_link_tx #(
  parameter int PEND_DEPTH   = 8,
  parameter int IDLE_GAP     = 4,
  parameter int VALID_PERIOD = 1
) (
  input  logic               clk_link,
  input  logic               reset,
  input  logic               enable,
  input  logic               l1a,
  input  logic [11:0]        bxid,
  input  logic [10:0]        nwords,
  input  logic [1:0]         pattern_sel,
  ldmx_daq_link_tx_if.master link,
  output logic [4:0]         pending,
  output logic [15:0]        dropped_count,
  output logic [31:0]        evt_count,
  output logic               active
);

  localparam int AW = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int GW = $clog2(IDLE_GAP + 1);

  localparam logic [31:0] IDLE_WORD = 32'h0000_00BC;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [3:0]  K_CTRL    = 4'b0001;
  localparam logic [3:0]  K_DATA    = 4'b0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOE,
    S_HDR,
    S_PAY,
    S_CKS,
    S_EOE
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Word strobe divider
  // ---------------------------------------------------------------------------
  logic [3:0] div_q;
  logic       strobe;

  assign strobe = (div_q == 4'd0);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_link) begin
    if (reset) begin
      div_q <= 4'd0;
    end else if (div_q == 4'(VALID_PERIOD - 1)) begin
      div_q <= 4'd0;
    end else begin
      div_q <= div_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-trigger queue (bxid FIFO)
  // ---------------------------------------------------------------------------
  logic [11:0]   fifo_mem [PEND_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    cnt_q;
  logic          full, push, pop, drop;

  assign full = (cnt_q == 5'(PEND_DEPTH));
  assign push = l1a && enable && (!full || pop);
  assign drop = l1a && enable && full && !pop;

  // NOTE: queue storage is not reset; the occupancy count alone decides validity.
  always_ff @(posedge clk_link) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bxid;
    end
  end

  always_ff @(posedge clk_link) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 5'd1;
        2'b01:   cnt_q <= cnt_q - 5'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign pending = cnt_q;

  always_ff @(posedge clk_link) begin
    if (reset) begin
      dropped_count <= 16'd0;
    end else if (drop && dropped_count != 16'hFFFF) begin
      dropped_count <= dropped_count + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame datapath state
  // ---------------------------------------------------------------------------
  logic [GW-1:0] gap_q, gap_d, gap_dec;
  logic [15:0]   idx_q, idx_d;
  logic [31:0]   cksum_q, cksum_d;
  logic [31:0]   lfsr_q, lfsr_d, lfsr_step;
  logic [10:0]   ev_nwords_q, ev_nwords_d;
  logic [1:0]    ev_pat_q, ev_pat_d;
  logic [31:0]   evt_d;
  logic [31:0]   data_d;
  logic [3:0]    k_d;
  logic          active_d;
  logic [31:0]   pay_word;

  assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
  assign gap_dec   = (gap_q == '0) ? '0 : gap_q - GW'(1);

  always_comb begin
    case (ev_pat_q)
      2'd0:    pay_word = {16'h0, idx_q};
      2'd1:    pay_word = {evt_count[15:0], idx_q};
      2'd2:    pay_word = lfsr_q;
      default: pay_word = 32'hA5A5_A5A5;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: the registered link word always belongs to state_q
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_link) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    state_d     = state_q;
    data_d      = link.link_data;
    k_d         = link.link_is_k;
    active_d    = active;
    gap_d       = gap_q;
    idx_d       = idx_q;
    cksum_d     = cksum_q;
    lfsr_d      = lfsr_q;
    ev_nwords_d = ev_nwords_q;
    ev_pat_d    = ev_pat_q;
    evt_d       = evt_count;
    pop         = 1'b0;

    if (strobe) begin
      case (state_q)
        S_IDLE: begin
          data_d   = IDLE_WORD;
          k_d      = K_CTRL;
          active_d = 1'b0;
          gap_d    = gap_dec;
          // The gap is spent on the strobe that brings the counter to zero,
          // so exactly IDLE_GAP idle words separate EOE from the next SOE.
          if (enable && cnt_q != 5'd0 && gap_dec == '0) begin
            pop         = 1'b1;
            state_d     = S_SOE;
            evt_d       = evt_count + 32'd1;
            ev_nwords_d = nwords;
            ev_pat_d    = pattern_sel;
            cksum_d     = 32'h0;
            idx_d       = 16'h0;
            data_d      = {fifo_mem[rd_ptr], evt_d[11:0], 8'hFB};
            k_d         = K_CTRL;
            active_d    = 1'b1;
          end
        end
        S_SOE: begin
          state_d = S_HDR;
          data_d  = {5'h0, ev_nwords_q, evt_count[15:0]};
          k_d     = K_DATA;
        end
        S_HDR, S_PAY: begin
          k_d = K_DATA;
          if (idx_q == {5'h0, ev_nwords_q}) begin
            state_d = S_CKS;
            data_d  = cksum_q;
          end else begin
            state_d = S_PAY;
            data_d  = pay_word;
            cksum_d = cksum_q ^ pay_word;
            idx_d   = idx_q + 16'd1;
            if (ev_pat_q == 2'd2) lfsr_d = lfsr_step;
          end
        end
        S_CKS: begin
          state_d = S_EOE;
          data_d  = {13'h0, ev_nwords_q, 8'hFD};
          k_d     = K_CTRL;
        end
        S_EOE: begin
          state_d  = S_IDLE;
          data_d   = IDLE_WORD;
          k_d      = K_CTRL;
          active_d = 1'b0;
          gap_d    = GW'(IDLE_GAP);
        end
        default: begin
          state_d  = S_IDLE;
          data_d   = IDLE_WORD;
          k_d      = K_CTRL;
          active_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_link) begin
    if (reset) begin
      link.link_data  <= IDLE_WORD;
      link.link_is_k  <= K_CTRL;
      link.link_valid <= 1'b0;
      active          <= 1'b0;
      gap_q           <= GW'(IDLE_GAP);
      idx_q           <= 16'h0;
      cksum_q         <= 32'h0;
      lfsr_q          <= 32'h1;
      ev_nwords_q     <= 11'h0;
      ev_pat_q        <= 2'd0;
      evt_count       <= 32'h0;
    end else begin
      link.link_data  <= data_d;
      link.link_is_k  <= k_d;
      link.link_valid <= strobe;
      active          <= active_d;
      gap_q           <= gap_d;
      idx_q           <= idx_d;
      cksum_q         <= cksum_d;
      lfsr_q          <= lfsr_d;
      ev_nwords_q     <= ev_nwords_d;
      ev_pat_q        <= ev_pat_d;
      evt_count       <= evt_d;
    end
  end

endmodule

// File: tb/tb_ldmx_daq_link_tx.sv
// Scoreboard bench for ldmx_daq_link_tx: stimulus queues expected link words,
// a negedge monitor pops and compares every non-idle word the DUT presents.
module tb_ldmx_daq_link_tx;

  localparam int IDLE_GAP = 4;
  localparam logic [31:0] IDLE_WORD = 32'h0000_00BC;

  logic clk_link = 1'b0;
  always #5 clk_link = ~clk_link;

  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        l1a = 1'b0;
  logic [11:0] bxid = 12'h0;
  logic [10:0] nwords = 11'h0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [4:0]  pending;
  logic [15:0] dropped_count;
  logic [31:0] evt_count;
  logic        active;

  logic        l1a3 = 1'b0;
  logic [11:0] bxid3 = 12'h0;
  logic [10:0] nwords3 = 11'd2;
  logic [4:0]  pending3;
  logic [15:0] dropped_count3;
  logic [31:0] evt_count3;
  logic        active3;

  ldmx_daq_link_tx_if lif ();
  ldmx_daq_link_tx_if lif3 ();

  ldmx_daq_link_tx #(.PEND_DEPTH(8), .IDLE_GAP(IDLE_GAP), .VALID_PERIOD(1)) u_dut (
    .clk_link      (clk_link),
    .reset         (reset),
    .enable        (enable),
    .l1a           (l1a),
    .bxid          (bxid),
    .nwords        (nwords),
    .pattern_sel   (pattern_sel),
    .link          (lif),
    .pending       (pending),
    .dropped_count (dropped_count),
    .evt_count     (evt_count),
    .active        (active)
  );

  ldmx_daq_link_tx #(.PEND_DEPTH(4), .IDLE_GAP(2), .VALID_PERIOD(3)) u_dut3 (
    .clk_link      (clk_link),
    .reset         (reset),
    .enable        (enable),
    .l1a           (l1a3),
    .bxid          (bxid3),
    .nwords        (nwords3),
    .pattern_sel   (2'd0),
    .link          (lif3),
    .pending       (pending3),
    .dropped_count (dropped_count3),
    .evt_count     (evt_count3),
    .active        (active3)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] data;
    logic [3:0]  k;
    bit          gap_chk;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_evt  = 32'h0;
  logic [31:0] m_lfsr = 32'h1;
  int          m_drop = 0;

  task automatic push_frame(input logic [11:0] bx, input logic [10:0] nw,
                            input logic [1:0] pat, input bit gap_chk);
    logic [31:0] w;
    logic [31:0] x;
    m_evt = m_evt + 32'd1;
    x = 32'h0;
    exp_q.push_back('{data: {bx, m_evt[11:0], 8'hFB}, k: 4'b0001, gap_chk: gap_chk});
    exp_q.push_back('{data: {5'h0, nw, m_evt[15:0]}, k: 4'b0000, gap_chk: 1'b0});
    for (int i = 0; i < int'(nw); i++) begin
      case (pat)
        2'd0: w = 32'(i);
        2'd1: w = {m_evt[15:0], 16'(i)};
        2'd2: begin
          w = m_lfsr;
          m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
        end
        default: w = 32'hA5A5_A5A5;
      endcase
      x = x ^ w;
      exp_q.push_back('{data: w, k: 4'b0000, gap_chk: 1'b0});
    end
    exp_q.push_back('{data: x, k: 4'b0000, gap_chk: 1'b0});
    exp_q.push_back('{data: {13'h0, nw, 8'hFD}, k: 4'b0001, gap_chk: 1'b0});
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int   idle_run = 0;
  int   act_run  = 0;
  logic en_prev  = 1'b0;

  always @(negedge clk_link) begin
    exp_t e;
    if (reset) begin
      idle_run = 0;
      act_run  = 0;
    end else if (lif.link_valid) begin
      if (lif.link_data == IDLE_WORD && lif.link_is_k == 4'b0001) begin
        idle_run++;
        check("idle_active", 32'(active), 32'h0);
      end else begin
        if (lif.link_is_k == 4'b0001 && lif.link_data[7:0] == 8'hFB) begin
          check("soe_enable", 32'(en_prev), 32'h1);
          act_run = 0;
        end
        if (active) act_run++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_word: got %h k=%b, expected none", lif.link_data, lif.link_is_k);
        end else begin
          e = exp_q.pop_front();
          check("link_data", lif.link_data, e.data);
          check("link_is_k", 32'(lif.link_is_k), 32'(e.k));
          if (e.gap_chk) check("idle_gap", 32'(idle_run), IDLE_GAP);
        end
        if (lif.link_is_k == 4'b0001 && lif.link_data[7:0] == 8'hFD) begin
          check("frame_len", 32'(act_run), 32'(lif.link_data[18:8]) + 32'd4);
          idle_run = 0;
        end
      end
    end
    en_prev = enable;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic pulse(input logic [11:0] bx);
    l1a  = 1'b1;
    bxid = bx;
    @(posedge clk_link); #1;
    l1a  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(posedge clk_link);
      i++;
    end
    #1;
    check("drain", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    repeat (IDLE_GAP + 4) @(posedge clk_link);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // VALID_PERIOD=3 capture
  logic        v3 [40];
  logic [31:0] d3 [40];
  logic [31:0] exp3 [6];

  initial begin
    int nv, last, ts, te;

    reset = 1'b1;
    repeat (3) @(posedge clk_link);
    #1 reset = 1'b0;
    @(negedge clk_link);
    check("rst_data",    lif.link_data, IDLE_WORD);
    check("rst_k",       32'(lif.link_is_k), 32'h1);
    check("rst_valid",   32'(lif.link_valid), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_dropped", 32'(dropped_count), 32'h0);
    check("rst_evt",     evt_count, 32'h0);
    check("rst_active",  32'(active), 32'h0);
    @(posedge clk_link); #1;
    enable = 1'b1;

    // Strobe divider: VALID_PERIOD=3, nwords=2, pattern 0
    repeat (20) @(posedge clk_link);
    #1;
    exp3[0] = 32'h4560_01FB; exp3[1] = 32'h0002_0001; exp3[2] = 32'h0;
    exp3[3] = 32'h1;         exp3[4] = 32'h1;         exp3[5] = 32'h0000_02FD;
    l1a3 = 1'b1; bxid3 = 12'h456;
    @(posedge clk_link); #1 l1a3 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_link);
      v3[i] = lif3.link_valid;
      d3[i] = lif3.link_data;
    end
    nv = 0; last = -1; ts = -1; te = -1;
    for (int i = 0; i < 40; i++) begin
      if (v3[i]) begin
        if (last >= 0) check("vp_spacing", 32'(i - last), 32'd3);
        last = i;
        if (d3[i] != IDLE_WORD) begin
          if (nv < 6) check("vp_word", d3[i], exp3[nv]);
          if (d3[i] == 32'h4560_01FB) ts = i;
          if (d3[i] == 32'h0000_02FD) te = i;
          nv++;
        end
      end else if (i > 0) begin
        check("vp_hold", d3[i], d3[i-1]);
      end
    end
    check("vp_words", 32'(nv), 32'd6);
    check("vp_span", 32'(te - ts + 3), 32'd18);
    @(posedge clk_link); #1;

    // Single event, latency
    nwords = 11'd3; pattern_sel = 2'd0;
    push_frame(12'h123, 11'd3, 2'd0, 1'b0);
    pulse(12'h123);
    @(negedge clk_link);
    check("latency_pending", 32'(pending), 32'h1);
    @(negedge clk_link);
    check("latency_soe",   lif.link_data, 32'h1230_01FB);
    check("latency_valid", 32'(lif.link_valid), 32'h1);
    drain(100);
    check("evt_after_single", evt_count, 32'd1);

    // Empty payload, constant pattern
    nwords = 11'd0; pattern_sel = 2'd3;
    push_frame(12'h0AB, 11'd0, 2'd3, 1'b0);
    pulse(12'h0AB);
    drain(50);
    check("evt_after_empty", evt_count, 32'd2);

    // Burst of 10 L1As into an 8-deep queue, LFSR payload
    nwords = 11'd16; pattern_sel = 2'd2;
    for (int i = 0; i < 9; i++) push_frame(12'h200 + 12'(i), 11'd16, 2'd2, i != 0);
    for (int i = 0; i < 10; i++) begin
      l1a = 1'b1; bxid = 12'h200 + 12'(i);
      @(posedge clk_link); #1;
    end
    l1a = 1'b0;
    m_drop++;
    @(negedge clk_link);
    check("burst_pending", 32'(pending), 32'd8);
    check("burst_dropped", 32'(dropped_count), 32'(m_drop));
    drain(400);
    check("evt_after_burst", evt_count, 32'd11);
    check("dropped_after_burst", 32'(dropped_count), 32'(m_drop));

    // enable dropped mid-frame with three triggers queued
    nwords = 11'd16; pattern_sel = 2'd1;
    for (int i = 0; i < 4; i++) push_frame(12'h300 + 12'(i), 11'd16, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      l1a = 1'b1; bxid = 12'h300 + 12'(i);
      @(posedge clk_link); #1;
    end
    l1a = 1'b0;
    repeat (4) @(posedge clk_link);
    #1 enable = 1'b0;
    pulse(12'hEEE);
    repeat (40) @(posedge clk_link);
    @(negedge clk_link);
    check("dis_pending", 32'(pending), 32'd3);
    check("dis_active",  32'(active), 32'h0);
    check("dis_dropped", 32'(dropped_count), 32'(m_drop));
    check("dis_queued",  32'(exp_q.size()), 32'd60);
    @(posedge clk_link); #1 enable = 1'b1;
    drain(300);
    check("evt_after_enable", evt_count, 32'd15);

    // Reset during a 100-word payload
    nwords = 11'd100; pattern_sel = 2'd0;
    push_frame(12'h0CD, 11'd100, 2'd0, 1'b0);
    pulse(12'h0CD);
    pulse(12'h0CE);
    pulse(12'h0CF);
    repeat (20) @(posedge clk_link);
    @(negedge clk_link);
    check("pre_rst_pending", 32'(pending), 32'd2);
    @(posedge clk_link); #1 reset = 1'b1;
    repeat (2) @(posedge clk_link);
    #1 reset = 1'b0;
    exp_q.delete();
    m_evt = 32'h0; m_lfsr = 32'h1; m_drop = 0;
    @(negedge clk_link);
    check("abort_data",    lif.link_data, IDLE_WORD);
    check("abort_k",       32'(lif.link_is_k), 32'h1);
    check("abort_pending", 32'(pending), 32'h0);
    check("abort_evt",     evt_count, 32'h0);
    check("abort_active",  32'(active), 32'h0);
    repeat (150) @(posedge clk_link);
    #1;
    check("abort_quiet_evt", evt_count, 32'h0);

    // Operation resumes after the abort
    nwords = 11'd1; pattern_sel = 2'd0;
    push_frame(12'h777, 11'd1, 2'd0, 1'b0);
    pulse(12'h777);
    drain(50);
    check("evt_after_resume", evt_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
